// File: rtl/calc_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// valid/ready handshakes on both sides, sign handling and significant-digit count.
module calc_bin2bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_value,
    input  logic                         in_signed,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic                         out_neg,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned NW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic            out_valid_q;
    logic [BW-1:0]   out_bcd_q;
    logic            out_neg_q;
    logic [NW-1:0]   out_ndig_q;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_d;
    logic [NW-1:0]    ndig_d;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;

    assign in_ready  = ena && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_neg   = out_neg_q;
    assign out_ndig  = out_ndig_q;

    // Magnitude as unsigned WIDTH bits so the most-negative input maps cleanly.
    always_comb begin
        in_neg = in_signed & in_value[WIDTH-1];
        in_mag = in_neg ? (~in_value + WIDTH'(1)) : in_value;
    end

    // Add-3 correction followed by one left shift of {bcd, shift}.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = BW'({bcd_adj, shift_q[WIDTH-1]});

        ndig_d = NW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] != 4'd0) begin
                ndig_d = NW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_neg_q   <= 1'b0;
            out_ndig_q  <= NW'(1);
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= in_mag;
                        neg_q   <= in_neg;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_bcd_q   <= bcd_d;
                        out_neg_q   <= neg_q;
                        out_ndig_q  <= ndig_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_bin2bcd_seq.sv
// Directed self-checking bench for calc_bin2bcd_seq: conversions, latency,
// backpressure, mid-conversion reset and enable stalls.
module tb_calc_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_neg;
    logic [2:0]  out_ndig;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_bin2bcd_seq #(
        .WIDTH (16),
        .DIGITS(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bcd  (out_bcd),
        .out_neg  (out_neg),
        .out_ndig (out_ndig)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one value for a single accepting edge; returns #1 after that edge.
    task automatic accept(input logic [15:0] v, input logic s);
        @(negedge clk);
        in_value  = v;
        in_signed = s;
        in_valid  = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] v, input logic s,
                           input logic [19:0] exp_bcd, input logic exp_neg,
                           input logic [2:0] exp_ndig);
        int n;
        accept(v, s);
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'd16);
        check({tag, "_bcd"}, 32'(out_bcd), 32'(exp_bcd));
        check({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
        check({tag, "_ndig"}, 32'(out_ndig), 32'(exp_ndig));
        @(posedge clk);
        #1;
        check({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_xfer_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [19:0] held;

        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
        check("rst_neg", 32'(out_neg), 32'd0);
        check("rst_ndig", 32'(out_ndig), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        run_vec("zero",     16'h0000, 1'b0, 20'h00000, 1'b0, 3'd1);
        run_vec("ffff_u",   16'hFFFF, 1'b0, 20'h65535, 1'b0, 3'd5);
        run_vec("ffff_s",   16'hFFFF, 1'b1, 20'h00001, 1'b1, 3'd1);
        run_vec("8000_s",   16'h8000, 1'b1, 20'h32768, 1'b1, 3'd5);
        run_vec("8000_u",   16'h8000, 1'b0, 20'h32768, 1'b0, 3'd5);
        run_vec("7fff_s",   16'h7FFF, 1'b1, 20'h32767, 1'b0, 3'd5);
        run_vec("03e8",     16'h03E8, 1'b0, 20'h01000, 1'b0, 3'd4);
        run_vec("nine",     16'h0009, 1'b0, 20'h00009, 1'b0, 3'd1);
        run_vec("ten",      16'h000A, 1'b0, 20'h00010, 1'b0, 3'd2);
        run_vec("neg100",   16'hFF9C, 1'b1, 20'h00100, 1'b1, 3'd3);

        // Backpressure: result held while out_ready is low, inputs refused.
        out_ready = 1'b0;
        accept(16'h1234, 1'b0);
        wait_valid(n);
        check("bp_lat", 32'(n), 32'd16);
        check("bp_bcd", 32'(out_bcd), 32'h04660);
        held = out_bcd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_value = 16'hAAAA;
            in_valid = 1'b1;
            check("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_stable", 32'(out_bcd), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_xfer", 32'(out_valid), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ghost", 32'(out_valid), 32'd0);

        // Reset on the 7th SHIFT edge discards the conversion.
        accept(16'd12345, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_bcd", 32'(out_bcd), 32'd0);
        check("mrst_ndig", 32'(out_ndig), 32'd1);
        check("mrst_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("mrst_no_valid", 32'(out_valid), 32'd0);
        run_vec("post_rst", 16'h0042, 1'b0, 20'h00066, 1'b0, 3'd2);

        // Enable stall mid-SHIFT, then no transfer while disabled in DONE.
        out_ready = 1'b0;
        accept(16'd9999, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        ena = 1'b0;
        check("stall_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        ena = 1'b1;
        wait_valid(n);
        check("stall_lat", 32'(n + 9), 32'd20);
        check("stall_bcd", 32'(out_bcd), 32'h09999);
        check("stall_ndig", 32'(out_ndig), 32'd4);
        ena       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("dis_hold", 32'(out_valid), 32'd1);
        check("dis_ready", 32'(in_ready), 32'd0);
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("dis_xfer", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
